// File: rtl/rvvi_stream_scheduler.sv
// RVVI trace frame scheduler: buffers probe frames in a small FIFO and
// serialises each as a header beat plus 32-bit payload beats on a
// valid/ready link. Frames without CSR writes are sent in short form.
module rvvi_stream_scheduler #(
    parameter int XLEN              = 64,
    parameter int MAX_CSRS          = 5,
    parameter int RVVI_WIDTH        = 128 + 4*XLEN + MAX_CSRS*(XLEN+16),
    parameter int FRAME_COUNT_WIDTH = 16,
    parameter int DEPTH             = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         TraceEn,
    input  logic                         DutValid,
    input  logic [RVVI_WIDTH-1:0]        DutRvvi,
    input  logic [FRAME_COUNT_WIDTH-1:0] DutFrameCount,
    output logic                         RvviStall,
    output logic                         RvviTValid,
    output logic [31:0]                  RvviTData,
    output logic                         RvviTLast,
    input  logic                         RvviTReady,
    output logic [15:0]                  DropCount,
    output logic                         Overflow
);
    localparam int BASE_BEATS = (128 + 4*XLEN) / 32;
    localparam int FULL_BEATS = (RVVI_WIDTH + 31) / 32;
    localparam int PADW       = FULL_BEATS * 32;
    localparam int PW         = $clog2(DEPTH);
    localparam int CW         = $clog2(DEPTH + 1);
    localparam int IW         = $clog2(FULL_BEATS);
    localparam logic [7:0]    BASE_B8  = 8'(BASE_BEATS);
    localparam logic [7:0]    FULL_B8  = 8'(FULL_BEATS);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
    state_t state, state_next;

    logic [RVVI_WIDTH-1:0]        fifo_data [DEPTH];
    logic [FRAME_COUNT_WIDTH-1:0] fifo_fc   [DEPTH];
    logic [DEPTH-1:0]             fifo_short;
    logic [PW-1:0]                wr_ptr, rd_ptr;
    logic [CW-1:0]                count, count_next;
    logic [IW-1:0]                idx, idx_next;
    logic                         accept, pop, full_eff, enq, drop, full_drop;
    logic                         last_beat;
    logic [7:0]                   head_beats;
    logic [15:0]                  head_fc16;
    logic [PADW-1:0]              head_padded;

    // Frame sequence number fitted to the 16-bit header field
    if (FRAME_COUNT_WIDTH >= 16) begin : g_fc_trunc
        always_comb head_fc16 = fifo_fc[rd_ptr][15:0];
    end else begin : g_fc_ext
        always_comb head_fc16 = {{(16-FRAME_COUNT_WIDTH){1'b0}}, fifo_fc[rd_ptr]};
    end

    // Head-of-FIFO frame view: beat count, zero-padded payload, last-beat flag
    always_comb begin
        head_beats  = fifo_short[rd_ptr] ? BASE_B8 : FULL_B8;
        head_padded = '0;
        head_padded[RVVI_WIDTH-1:0] = fifo_data[rd_ptr];
        last_beat   = (state == PAYLOAD) && (8'(idx) == head_beats - 8'd1);
    end

    // Handshake and FIFO admission; a last-beat pop frees a slot for a same-cycle enqueue
    always_comb begin
        accept     = RvviTValid & RvviTReady;
        pop        = accept & last_beat;
        full_eff   = (count == DEPTH_C) & ~pop;
        enq        = DutValid & TraceEn & ~full_eff;
        drop       = DutValid & ~enq;
        full_drop  = DutValid & TraceEn & full_eff;
        count_next = count + CW'(enq) - CW'(pop);
    end

    // Next-state and stream outputs
    always_comb begin
        state_next = state;
        idx_next   = idx;
        RvviTValid = 1'b0;
        RvviTData  = '0;
        RvviTLast  = 1'b0;
        case (state)
            IDLE: begin
                // Jump straight to HEADER on the enqueue so the header appears the next cycle
                if (count != '0 || enq) state_next = HEADER;
            end
            HEADER: begin
                RvviTValid = 1'b1;
                RvviTData  = {head_fc16, head_beats, 8'hA5};
                if (accept) begin
                    state_next = PAYLOAD;
                    idx_next   = '0;
                end
            end
            PAYLOAD: begin
                RvviTValid = 1'b1;
                RvviTData  = head_padded[int'(idx)*32 +: 32];
                RvviTLast  = last_beat;
                if (accept) begin
                    if (last_beat) begin
                        state_next = (count_next != '0) ? HEADER : IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state and beat index
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_data[wr_ptr]  <= DutRvvi;
            fifo_fc[wr_ptr]    <= DutFrameCount;
            fifo_short[wr_ptr] <= (DutRvvi[107:96] == 12'd0);
        end
    end

    // Stall request, drop counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            RvviStall <= 1'b0;
            DropCount <= '0;
            Overflow  <= 1'b0;
        end else begin
            RvviStall <= TraceEn & (count_next >= STALL_TH);
            if (drop && DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
            if (full_drop) Overflow <= 1'b1;
        end
    end
endmodule
